// File: rtl/spi_dev_pkg.sv
// Shared definitions for the SPI device receiver.
// Contents:
//   - field widths for the command, address, data and byte-enable fields
//   - the two recognised command opcodes
//   - the frame FSM state enum
//   - a helper that classifies a command byte
package spi_dev_pkg;

    localparam int CMD_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [CMD_W-1:0]  CMD_WRITE = 8'h02;
    localparam logic [CMD_W-1:0]  CMD_READ  = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd4;
    localparam logic [BE_W-1:0]   BE_FULL   = 4'hF;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        WR_REQ,
        DUMMY,
        RD_REQ,
        RD_WAIT,
        RD_OUT,
        DISCARD
    } state_t;

    function automatic logic is_known_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronizes the asynchronous SPI pins into clk_i and detects edges.
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   spi_sclk/cs/sdi0    raw SPI pins
//   sclk_rise/fall      one-cycle pulses on synchronized sclk edges
//   cs_rise/fall        one-cycle pulses on synchronized chip-select edges
//   cs_level            synchronized chip-select level
//   sdi_level           synchronized MOSI, aligned with the sclk pulses
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sclk,
    input  logic spi_cs,
    input  logic spi_sdi0,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_level,
    output logic sdi_level
);

    localparam int NSIG = 3;

    logic [NSIG-1:0] raw;
    logic [NSIG-1:0] sync_out;
    logic [1:0]      prev_reg;

    // bit 0 = sclk, bit 1 = cs, bit 2 = sdi; all go through equal-depth
    // chains so sdi stays aligned with the detected sclk edge.
    assign raw = {spi_sdi0, spi_cs, spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < NSIG; gi++) begin : g_sig
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= (chain_reg << 1) | SYNC_STAGES'(raw[gi]);
                end
            end

            assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= sync_out[1:0];
        end
    end

    assign sclk_rise = sync_out[0] & ~prev_reg[0];
    assign sclk_fall = ~sync_out[0] & prev_reg[0];
    assign cs_rise   = sync_out[1] & ~prev_reg[1];
    assign cs_fall   = ~sync_out[1] & prev_reg[1];
    assign cs_level  = sync_out[1];
    assign sdi_level = sync_out[2];

endmodule

// File: rtl/spi_dev_rx.sv
// SPI (mode 0) device that turns frames into 32-bit memory bus transfers.
// Frame: cmd[7:0], addr[31:0], payload. 0x02 = burst write, 0x03 = single
// read with DUMMY_CYC sclk cycles between address and read data.
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   spi_sclk/cs/sdi0    SPI inputs (cs active low), spi_sdo0 MISO
//   mem_*               request/grant memory bus, rvalid/rdata response
//   err_o               one-cycle pulse when read data missed the dummy window
//   busy_o              frame or bus transfer in progress
module spi_dev_rx
    import spi_dev_pkg::*;
#(
    parameter int DUMMY_CYC   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_sdi0,
    output logic              spi_sdo0,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BE_W-1:0]   mem_be_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic              busy_o
);

    localparam int DCNT_W = $clog2(DUMMY_CYC + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_level, sdi_level;

    spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_sdi0  (spi_sdi0),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_level  (cs_level),
        .sdi_level (sdi_level)
    );

    state_t              state_reg;
    logic [5:0]          bit_cnt_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [CMD_W-1:0]    cmd_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DCNT_W-1:0]   dummy_cnt_reg;
    logic                req_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [BE_W-1:0]     be_reg;
    logic                err_reg;
    logic                sdo_reg;
    logic                abort_reg;       // cs rose while a request was pending
    logic                drop_rvalid_reg; // next rvalid belongs to an abandoned read
    logic                underrun_reg;    // dummy window ended before the grant

    logic [DATA_W-1:0]   shift_in;
    logic                dummy_end;
    logic                in_rd_phase;

    assign shift_in    = {shift_reg[DATA_W-2:0], sdi_level};
    assign in_rd_phase = (state_reg == RD_REQ) || (state_reg == RD_WAIT) ||
                         (state_reg == DUMMY);
    // Last dummy clock: the following falling edge must present data bit 31.
    assign dummy_end   = sclk_rise && (dummy_cnt_reg == DCNT_W'(DUMMY_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            cmd_reg         <= '0;
            addr_reg        <= '0;
            dummy_cnt_reg   <= '0;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            mem_addr_reg    <= '0;
            wdata_reg       <= '0;
            be_reg          <= '0;
            err_reg         <= 1'b0;
            sdo_reg         <= 1'b0;
            abort_reg       <= 1'b0;
            drop_rvalid_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (state_reg != RD_OUT || cs_level) begin
                sdo_reg <= 1'b0;
            end
            // A 1-bit drop flag assumes the stale rvalid shows up before the
            // next read is granted (at least one full frame later).
            if (mem_rvalid_i && drop_rvalid_reg) begin
                drop_rvalid_reg <= 1'b0;
            end
            if (in_rd_phase && sclk_rise) begin
                dummy_cnt_reg <= dummy_cnt_reg + DCNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_reg   <= CMD;
                        bit_cnt_reg <= '0;
                    end
                end

                CMD: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        if (bit_cnt_reg == 6'(CMD_W - 1)) begin
                            cmd_reg     <= shift_in[CMD_W-1:0];
                            bit_cnt_reg <= '0;
                            state_reg   <= is_known_cmd(shift_in[CMD_W-1:0]) ? ADDR : DISCARD;
                        end
                    end
                end

                ADDR: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        if (bit_cnt_reg == 6'(ADDR_W - 1)) begin
                            bit_cnt_reg <= '0;
                            if (cmd_reg == CMD_WRITE) begin
                                addr_reg  <= shift_in;
                                state_reg <= WDATA;
                            end else begin
                                mem_addr_reg  <= shift_in;
                                wdata_reg     <= '0;
                                we_reg        <= 1'b0;
                                be_reg        <= BE_FULL;
                                req_reg       <= 1'b1;
                                dummy_cnt_reg <= '0;
                                underrun_reg  <= 1'b0;
                                state_reg     <= RD_REQ;
                            end
                        end
                    end
                end

                WDATA: begin
                    // cs rising here drops any partial word
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        if (bit_cnt_reg == 6'(DATA_W - 1)) begin
                            bit_cnt_reg  <= '0;
                            mem_addr_reg <= addr_reg;
                            addr_reg     <= addr_reg + ADDR_STEP;
                            wdata_reg    <= shift_in;
                            we_reg       <= 1'b1;
                            be_reg       <= BE_FULL;
                            req_reg      <= 1'b1;
                            state_reg    <= WR_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (cs_rise) begin
                        abort_reg <= 1'b1;
                    end
                    // Keep receiving the next word while waiting for the grant;
                    // the counter wraps so word alignment survives a long stall.
                    if (sclk_rise && !abort_reg && !cs_rise) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= (bit_cnt_reg == 6'(DATA_W - 1)) ? 6'd0 : bit_cnt_reg + 6'd1;
                    end
                    if (mem_gnt_i) begin
                        req_reg <= 1'b0;
                        if (abort_reg || cs_rise) begin
                            abort_reg <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= WDATA;
                        end
                    end
                end

                RD_REQ: begin
                    if (cs_rise) begin
                        abort_reg <= 1'b1;
                    end
                    if (dummy_end && !underrun_reg && !abort_reg && !cs_rise) begin
                        underrun_reg <= 1'b1;
                        err_reg      <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        req_reg <= 1'b0;
                        if (abort_reg || cs_rise) begin
                            abort_reg       <= 1'b0;
                            drop_rvalid_reg <= 1'b1;
                            state_reg       <= IDLE;
                        end else if (underrun_reg || dummy_end) begin
                            // Too late for this frame: send zeros, eat the rvalid
                            shift_reg       <= '0;
                            bit_cnt_reg     <= '0;
                            drop_rvalid_reg <= 1'b1;
                            state_reg       <= RD_OUT;
                        end else begin
                            state_reg <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (cs_rise) begin
                        drop_rvalid_reg <= !(mem_rvalid_i && !drop_rvalid_reg);
                        state_reg       <= IDLE;
                    end else if (mem_rvalid_i && !drop_rvalid_reg) begin
                        shift_reg <= mem_rdata_i;
                        if (dummy_end) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= RD_OUT;
                        end else begin
                            state_reg <= DUMMY;
                        end
                    end else if (dummy_end) begin
                        shift_reg       <= '0;
                        bit_cnt_reg     <= '0;
                        err_reg         <= 1'b1;
                        drop_rvalid_reg <= 1'b1;
                        state_reg       <= RD_OUT;
                    end
                end

                DUMMY: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end else if (dummy_end) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= RD_OUT;
                    end
                end

                RD_OUT: begin
                    if (cs_rise) begin
                        sdo_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (sclk_fall) begin
                        if (bit_cnt_reg == 6'(DATA_W)) begin
                            sdo_reg   <= 1'b0;
                            state_reg <= DISCARD;
                        end else begin
                            sdo_reg     <= shift_reg[DATA_W-1];
                            shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                        end
                    end
                end

                DISCARD: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign spi_sdo0    = sdo_reg;
    assign mem_req_o   = req_reg;
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign mem_be_o    = be_reg;
    assign err_o       = err_reg;
    assign busy_o      = (state_reg != IDLE) || drop_rvalid_reg;

endmodule

// File: doc/spi_dev_rx.md
SPI_DEV_RX -- requirements
Module: spi_dev_rx

Interface
REQ-001 SHALL have parameters: DUMMY_CYC, default 8, SPI clocks between read address and read data; SYNC_STAGES, default 2, synchronizer depth.
REQ-002 SHALL have ports: clk_i input 1 system clock; rst_i input 1 reset (one clock; reset is asynchronous and active-high).
REQ-003 SHALL have ports: spi_sclk input 1 SPI clock (mode 0); spi_cs input 1 chip select, active low; spi_sdi0 input 1 MOSI; spi_sdo0 output 1 MISO.
REQ-004 SHALL have ports: mem_req_o output 1; mem_gnt_i input 1; mem_we_o output 1; mem_addr_o output 32; mem_wdata_o output 32; mem_be_o output 4; mem_rvalid_i input 1; mem_rdata_i input 32.
REQ-005 SHALL have ports: err_o output 1, one-cycle pulse on read-data underrun; busy_o output 1, high while a frame or bus transfer is in progress.

Function
REQ-006 SHALL synchronize spi_sclk, spi_cs and spi_sdi0 into clk_i through SYNC_STAGES flops; correct operation requires the clk_i period to be at most 1/8 of the spi_sclk period.
REQ-007 SHALL sample spi_sdi0 on the synchronized sclk rising edge and update spi_sdo0 on the falling edge, MSB first.
REQ-008 SHALL decode the frame as cmd[7:0], then addr[31:0], then the payload; commands: 0x02 write, 0x03 read; any other command goes to DISCARD until spi_cs rises.
REQ-009 SHALL use FSM states IDLE, CMD, ADDR, WDATA, WR_REQ, DUMMY, RD_REQ, RD_WAIT, RD_OUT, DISCARD; IDLE->CMD on the cs falling edge; CMD->ADDR after 8 bits; ADDR->WDATA or RD_REQ after 32 bits.
REQ-010 Write: after each 32 payload bits SHALL enter WR_REQ with mem_req_o=1, mem_we_o=1, mem_be_o=4'hF, addr and wdata latched, then return to WDATA on mem_gnt_i.
REQ-011 Write burst: each following 32-bit word SHALL write to the previous address +4, wrapping from 32'hFFFF_FFFC to 32'h0; a partial trailing word (<32 bits) at cs rise SHALL be dropped.
REQ-012 Read: SHALL issue mem_req_o=1, mem_we_o=0 at address end; hold the request until mem_gnt_i; capture mem_rdata_i on mem_rvalid_i; count DUMMY_CYC sclk rising edges in parallel.
REQ-013 SHALL shift the captured word out in RD_OUT over 32 sclk cycles, then drive spi_sdo0 to 0; reads are single-word.
REQ-014 If rvalid has not arrived when DUMMY_CYC ends, SHALL shift out 32'h0, pulse err_o, and discard the late rvalid.
REQ-015 mem_req_o SHALL stay asserted, with stable address, we, be and wdata, from assertion until the gnt cycle; req and gnt may both be high in the first cycle.
REQ-016 A cs rise at any point SHALL return the FSM to IDLE, except during WR_REQ/RD_REQ, where the request completes at gnt and the FSM then goes to IDLE (a pending read's rvalid is consumed and discarded).
REQ-017 A cs fall arriving while a bus request from the previous frame is still pending SHALL have its bits ignored until the FSM reaches IDLE (the frame is lost; busy_o shows this).
REQ-018 spi_sdo0 SHALL be 0 whenever spi_cs is high or the FSM is not in RD_OUT.

Reset
REQ-019 On rst_i SHALL force: FSM=IDLE; mem_req_o, mem_we_o, err_o, busy_o, spi_sdo0=0; mem_addr_o, mem_wdata_o=0; mem_be_o=4'h0; counters, shift registers and synchronizers cleared.
REQ-020 Reset mid-transfer SHALL drop the pending request immediately, with no completion.

Structure
REQ-021 Package spi_dev_pkg SHALL hold the state enum, the command constants (CMD_WRITE=8'h02, CMD_READ=8'h03) and the field widths.
REQ-022 The synchronizer and edge detector SHALL be the single sub-module spi_sync (per-signal sync plus rise/fall pulses).

Verification
REQ-023 Frame 02/00000080/DEADBEEF -> one write: addr 0x80, wdata 0xDEADBEEF, be 0xF, with gnt returned immediately.
REQ-024 Write burst at 0xFFFFFFFC with data 1, 2, gnt delayed 5 cycles -> writes 0xFFFFFFFC=1 and then 0x0=2; req stays stable while waiting.
REQ-025 Read 03/00000084 with rvalid 3 cycles after gnt and rdata 0x0000001E -> MISO shows 0x0000001E after 8 dummy clocks; err_o stays 0.
REQ-026 Read with rvalid withheld past the dummy window -> MISO shows 0x00000000; err_o pulses once.
REQ-027 cs raised after 20 address bits, then cmd 0x55 -> no request; DISCARD is followed by IDLE at cs rise.
REQ-028 rst_i asserted during WR_REQ -> mem_req_o is 0 in the next cycle, and the FSM is IDLE.
